shift_reg_sequencer: RTL and testbench
======================================

// Module: shift_reg_sequencer
// PURPOSE
//  Command-driven sequencer for the 4-bit shift-register datapath built from condmux slices.
//  Accepts LOAD / SHIFT-LEFT / SHIFT-RIGHT commands over a valid/ready handshake.
//  Drives the datapath's ENB mode bus, DIR, SEL and parallel-load data for the exact number of cycles.
//  Raises a one-cycle DONE pulse on completion. Sits between the top-level control and the register slices.
// PARAMETERS
//  WIDTH  4  datapath width; also the maximum shift count
//  CW     3  command shift-count width; CW >= $clog2(WIDTH)+1
// PORTS
//  CLK        in   1      single clock; all logic is on the rising edge
//  RESET      in   1      synchronous, active-high reset
//  CMD_VALID  in   1      command present
//  CMD_READY  out  1      sequencer can accept a command
//  CMD_OP     in   2      00 NOP, 01 LOAD, 10 SHIFT_L, 11 SHIFT_R
//  CMD_CNT    in   CW     number of shift cycles (shift ops only)
//  CMD_ROT    in   1      1 = rotate (feedback), 0 = serial in from SIN
//  CMD_DATA   in   WIDTH  parallel load value (LOAD only)
//  ABORT      in   1      cancel the current operation
//  ENB        out  2      datapath mode: 00 SHIFT, 01 LOAD, 10 HOLD, 11 reserved (never driven)
//  DIR        out  1      0 = left, 1 = right; valid when ENB == 00
//  SEL        out  1      condmux select: 0 = serial in, 1 = rotate feedback
//  PAR_OUT    out  WIDTH  load value to datapath; valid when ENB == 01
//  BUSY       out  1      operation in progress
//  DONE       out  1      one-cycle completion pulse
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: ENB=10, DIR=0, SEL=0, PAR_OUT=0, BUSY=0, DONE=0, CMD_READY=0.
//    CMD_READY rises the first cycle after RESET deasserts.
//  - FSM states: IDLE, LOAD, SHIFT, FIN. CMD_READY=1 only in IDLE.
//    Handshake: accept on CMD_VALID && CMD_READY; CMD_* fields are sampled at acceptance.
//  - IDLE -> LOAD on op 01: ENB=01 and PAR_OUT=CMD_DATA for exactly 1 cycle, then FIN.
//  - IDLE -> SHIFT on op 10/11 with CNT > 0:
//    ENB=00 for exactly CNT consecutive cycles.
//    DIR = op[0]; SEL = CMD_ROT; both held constant throughout.
//    Internal down-counter loaded with CNT at acceptance; leave SHIFT when it reaches 1.
//  - Op 00, or shift with CNT == 0: IDLE -> FIN directly; ENB stays 10.
//  - CNT > WIDTH is saturated to WIDTH.
//  - FIN: DONE=1, ENB=10, BUSY=0 for one cycle, then IDLE.
//    CMD_READY=0 in FIN, so back-to-back commands have a 1-cycle gap.
//  - Latency: accepted at edge t -> first active ENB in cycle t+1.
//    DONE in cycle t+N+1 (N=1 for LOAD, N=CNT for shift, N=0 for NOP).
//  - BUSY=1 in LOAD and SHIFT only.
//  - ABORT in LOAD/SHIFT: next cycle ENB=10, state IDLE, no DONE pulse, counter cleared.
//    ABORT in IDLE/FIN is ignored.
//  - RESET mid-operation: same as ABORT, plus reset values on every output; no DONE.
//  - Simultaneous ABORT and CMD_VALID in IDLE: the command is accepted (ABORT is ignored in IDLE).
//  - ENB=11 is never driven.
// STRUCTURE
//  - Package shift_seq_pkg:
//    op codes OP_NOP/OP_LOAD/OP_SHL/OP_SHR;
//    ENB codes ENB_SHIFT=2'b00, ENB_LOAD=2'b01, ENB_HOLD=2'b10;
//    state encoding.
//  - One sub-module, shift_seq_cnt: loadable CW-bit down-counter with a "last" flag and saturation.
//  - FSM and output registers stay in the top module.
// TESTING
//  1. Reset 3 cycles, release -> ENB=10, DONE=0, BUSY=0; CMD_READY=1 one cycle after release.
//  2. LOAD CMD_DATA=4'b1010 -> next cycle ENB=01, PAR_OUT=1010; following cycle DONE=1, ENB=10.
//  3. SHIFT_R CNT=3 ROT=1 -> ENB=00, DIR=1, SEL=1 for exactly 3 cycles; DONE at t+4; CMD_READY=1 at t+5.
//  4. SHIFT_L CNT=0, then NOP -> each gives DONE at t+1 with ENB never 00; CNT=7 -> exactly 4 shift cycles.
//  5. SHIFT_L CNT=4, ABORT in 2nd shift cycle -> next cycle ENB=10, IDLE, no DONE ever.
//     Same stimulus with RESET instead of ABORT -> reset values.
//  6. CMD_VALID held high with two queued LOADs -> second accepted only in IDLE after the first DONE;
//     PAR_OUT per command, with a 1-cycle gap.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer.
//   op_e    : command opcodes carried on CMD_OP
//   enb_e   : datapath mode codes driven on ENB (2'b11 is reserved and never used)
//   state_e : sequencer FSM states
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHL  = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ENB_SHIFT = 2'b00,
        ENB_LOAD  = 2'b01,
        ENB_HOLD  = 2'b10
    } enb_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_FIN
    } state_e;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable shift-count down-counter.
//   clk_i  : clock (rising edge)
//   rst_i  : synchronous active-high reset, clears the count
//   load_i : load cnt_i (saturated to WIDTH)
//   clr_i  : clear the count (abort); wins over load/dec
//   dec_i  : decrement by one, stops at zero
//   cnt_i  : requested shift count
//   last_o : count currently equals 1 (final shift cycle)
module shift_seq_cnt #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic          dec_i,
    input  logic [CW-1:0] cnt_i,
    output logic          last_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] load_val;

    always_comb begin
        // A register of WIDTH bits never needs more than WIDTH shifts.
        load_val = (cnt_i > CW'(WIDTH)) ? CW'(WIDTH) : cnt_i;
        count_d  = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CW'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for the condmux shift-register datapath.
// Accepts LOAD / SHIFT-LEFT / SHIFT-RIGHT / NOP commands over valid/ready,
// drives the datapath mode bus for the exact number of cycles and pulses
// DONE for one cycle on completion. All outputs are registered.
//   CLK, RESET          : clock, synchronous active-high reset
//   CMD_VALID/CMD_READY : command handshake (READY high only in IDLE)
//   CMD_OP/CNT/ROT/DATA : opcode, shift count, rotate select, load value
//   ABORT               : cancel an in-progress LOAD/SHIFT, no DONE
//   ENB, DIR, SEL       : datapath mode, shift direction, condmux select
//   PAR_OUT             : parallel load value (valid when ENB == LOAD)
//   BUSY, DONE          : operation in progress, one-cycle completion pulse
module shift_reg_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CW-1:0]    CMD_CNT,
    input  logic             CMD_ROT,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic             ABORT,
    output logic [1:0]       ENB,
    output logic             DIR,
    output logic             SEL,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             BUSY,
    output logic             DONE
);

    state_e           state_q;
    enb_e             enb_q;
    logic             dir_q;
    logic             sel_q;
    logic [WIDTH-1:0] par_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    logic             accept;
    logic             shift_go;
    logic             active;
    logic             cnt_last;

    // ready_q is only ever set while in IDLE, so it alone qualifies acceptance.
    assign accept   = CMD_VALID && ready_q;
    assign shift_go = CMD_OP[1] && (CMD_CNT != '0);
    assign active   = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

    shift_seq_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .load_i (accept && shift_go),
        .clr_i  (active && ABORT),
        .dec_i  (state_q == ST_SHIFT),
        .cnt_i  (CMD_CNT),
        .last_o (cnt_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            enb_q   <= ENB_HOLD;
            dir_q   <= 1'b0;
            sel_q   <= 1'b0;
            par_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        unique case (op_e'(CMD_OP))
                            OP_LOAD: begin
                                state_q <= ST_LOAD;
                                enb_q   <= ENB_LOAD;
                                par_q   <= CMD_DATA;
                                busy_q  <= 1'b1;
                            end
                            OP_SHL, OP_SHR: begin
                                if (shift_go) begin
                                    state_q <= ST_SHIFT;
                                    enb_q   <= ENB_SHIFT;
                                    dir_q   <= CMD_OP[0];
                                    sel_q   <= CMD_ROT;
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_FIN;
                                    done_q  <= 1'b1;
                                end
                            end
                            default: begin
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (ABORT) begin
                        state_q <= ST_IDLE;
                        enb_q   <= ENB_HOLD;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if ((state_q == ST_LOAD) || cnt_last) begin
                        state_q <= ST_FIN;
                        enb_q   <= ENB_HOLD;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    enb_q   <= ENB_HOLD;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign CMD_READY = ready_q;
    assign ENB       = enb_q;
    assign DIR       = dir_q;
    assign SEL       = sel_q;
    assign PAR_OUT   = par_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Testbench for shift_reg_sequencer: directed scenarios plus randomized
// commands checked against a transaction-level expectation of the outputs.
module tb_shift_reg_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = 3;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [CW-1:0]    CMD_CNT;
    logic             CMD_ROT;
    logic [WIDTH-1:0] CMD_DATA;
    logic             ABORT;
    logic [1:0]       ENB;
    logic             DIR;
    logic             SEL;
    logic [WIDTH-1:0] PAR_OUT;
    logic             BUSY;
    logic             DONE;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 CLK = ~CLK;

    shift_reg_sequencer #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_CNT   (CMD_CNT),
        .CMD_ROT   (CMD_ROT),
        .CMD_DATA  (CMD_DATA),
        .ABORT     (ABORT),
        .ENB       (ENB),
        .DIR       (DIR),
        .SEL       (SEL),
        .PAR_OUT   (PAR_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (CMD_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) check_val("ready_timeout", 32'(CMD_READY), 32'd1);
    endtask

    // Expected behaviour: N = 1 for LOAD, min(CNT, WIDTH) for shifts, 0 otherwise.
    // Cycles 1..N show the active mode, cycle N+1 the DONE pulse, cycle N+2 READY.
    // An abort during active cycle k gives HOLD/IDLE in cycle k+1 and no DONE.
    task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt, input logic rot,
                           input logic [WIDTH-1:0] data, input int abort_k, input bit abort_acc);
        int n;
        bit ok;
        logic [1:0] act;
        if (op == 2'b01)      n = 1;
        else if (op[1])       n = (int'(cnt) > int'(WIDTH)) ? int'(WIDTH) : int'(cnt);
        else                  n = 0;
        act = (op == 2'b01) ? 2'b01 : 2'b00;
        wait_ready(ok);
        if (!ok) return;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_CNT   = cnt;
        CMD_ROT   = rot;
        CMD_DATA  = data;
        ABORT     = abort_acc;
        @(negedge CLK);
        // Scramble the fields: the sequencer must have captured them already.
        CMD_VALID = 1'b0;
        ABORT     = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_CNT   = CW'($urandom);
        CMD_ROT   = 1'($urandom);
        CMD_DATA  = WIDTH'($urandom);
        for (int k = 1; k <= n; k++) begin
            check_val("act_enb", 32'(ENB), 32'(act));
            check_val("act_busy", 32'(BUSY), 32'd1);
            check_val("act_done", 32'(DONE), 32'd0);
            check_val("act_ready", 32'(CMD_READY), 32'd0);
            if (op == 2'b01) begin
                check_val("load_par", 32'(PAR_OUT), 32'(data));
            end else begin
                check_val("shift_dir", 32'(DIR), 32'(op[0]));
                check_val("shift_sel", 32'(SEL), 32'(rot));
            end
            if (k == abort_k) begin
                ABORT = 1'b1;
                @(negedge CLK);
                ABORT = 1'b0;
                check_val("abort_enb", 32'(ENB), 32'd2);
                check_val("abort_busy", 32'(BUSY), 32'd0);
                check_val("abort_done", 32'(DONE), 32'd0);
                check_val("abort_ready", 32'(CMD_READY), 32'd1);
                for (int j = 0; j < 3; j++) begin
                    @(negedge CLK);
                    check_val("abort_nodone", 32'(DONE), 32'd0);
                    check_val("abort_hold", 32'(ENB), 32'd2);
                end
                return;
            end
            @(negedge CLK);
        end
        check_val("fin_done", 32'(DONE), 32'd1);
        check_val("fin_enb", 32'(ENB), 32'd2);
        check_val("fin_busy", 32'(BUSY), 32'd0);
        check_val("fin_ready", 32'(CMD_READY), 32'd0);
        ABORT = 1'($urandom_range(0, 1));
        @(negedge CLK);
        ABORT = 1'b0;
        check_val("post_ready", 32'(CMD_READY), 32'd1);
        check_val("post_done", 32'(DONE), 32'd0);
        check_val("post_enb", 32'(ENB), 32'd2);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_enb"}, 32'(ENB), 32'd2);
        check_val({tag, "_dir"}, 32'(DIR), 32'd0);
        check_val({tag, "_sel"}, 32'(SEL), 32'd0);
        check_val({tag, "_par"}, 32'(PAR_OUT), 32'd0);
        check_val({tag, "_busy"}, 32'(BUSY), 32'd0);
        check_val({tag, "_done"}, 32'(DONE), 32'd0);
        check_val({tag, "_ready"}, 32'(CMD_READY), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int abort_k;
        logic [1:0] op;
        logic [CW-1:0] cnt;
        int n_exp;

        RESET     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_CNT   = '0;
        CMD_ROT   = 1'b0;
        CMD_DATA  = '0;
        ABORT     = 1'b0;

        // Reset for 3 cycles, then release.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("rst");
        RESET = 1'b0;
        @(negedge CLK);
        check_val("rst_ready_rise", 32'(CMD_READY), 32'd1);
        check_val("rst_idle_enb", 32'(ENB), 32'd2);

        // Directed commands.
        run_cmd(2'b01, 3'd0, 1'b0, 4'b1010, 0, 1'b0);   // LOAD 1010
        run_cmd(2'b11, 3'd3, 1'b1, 4'b0000, 0, 1'b0);   // SHIFT_R 3, rotate
        run_cmd(2'b10, 3'd0, 1'b0, 4'b0000, 0, 1'b0);   // SHIFT_L 0 -> immediate DONE
        run_cmd(2'b00, 3'd5, 1'b1, 4'b1111, 0, 1'b0);   // NOP
        run_cmd(2'b10, 3'd7, 1'b0, 4'b0000, 0, 1'b0);   // SHIFT_L 7 saturates to 4
        run_cmd(2'b10, 3'd4, 1'b1, 4'b0000, 2, 1'b0);   // abort in 2nd shift cycle
        run_cmd(2'b01, 3'd0, 1'b0, 4'b0110, 0, 1'b1);   // ABORT with command in IDLE
        run_cmd(2'b01, 3'd0, 1'b0, 4'b1001, 0, 1'b0);   // leaves PAR_OUT nonzero

        // RESET in the 2nd shift cycle of SHIFT_L 4 with rotate.
        wait_ready(ok);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b10;
        CMD_CNT   = 3'd4;
        CMD_ROT   = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check_val("rst_op_enb1", 32'(ENB), 32'd0);
        @(negedge CLK);
        check_val("rst_op_enb2", 32'(ENB), 32'd0);
        check_val("rst_op_sel", 32'(SEL), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_reset_vals("midrst");
        @(negedge CLK);
        check_val("midrst_ready", 32'(CMD_READY), 32'd1);
        for (int j = 0; j < 4; j++) begin
            check_val("midrst_nodone", 32'(DONE), 32'd0);
            @(negedge CLK);
        end

        // Two LOADs with CMD_VALID held high throughout.
        wait_ready(ok);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b01;
        CMD_DATA  = 4'b0011;
        @(negedge CLK);
        check_val("b2b_enb_a", 32'(ENB), 32'd1);
        check_val("b2b_par_a", 32'(PAR_OUT), 32'h3);
        CMD_DATA = 4'b1100;
        @(negedge CLK);
        check_val("b2b_done_a", 32'(DONE), 32'd1);
        check_val("b2b_ready_fin", 32'(CMD_READY), 32'd0);
        @(negedge CLK);
        check_val("b2b_gap_enb", 32'(ENB), 32'd2);
        check_val("b2b_gap_ready", 32'(CMD_READY), 32'd1);
        check_val("b2b_gap_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check_val("b2b_enb_b", 32'(ENB), 32'd1);
        check_val("b2b_par_b", 32'(PAR_OUT), 32'hC);
        check_val("b2b_ready_b", 32'(CMD_READY), 32'd0);
        @(negedge CLK);
        check_val("b2b_done_b", 32'(DONE), 32'd1);
        @(negedge CLK);

        // Randomized command stream.
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom);
            cnt = CW'($urandom);
            if (op == 2'b01)  n_exp = 1;
            else if (op[1])   n_exp = (int'(cnt) > int'(WIDTH)) ? int'(WIDTH) : int'(cnt);
            else              n_exp = 0;
            abort_k = 0;
            if (n_exp > 0 && $urandom_range(0, 4) == 0) abort_k = $urandom_range(1, n_exp);
            run_cmd(op, cnt, 1'($urandom), WIDTH'($urandom), abort_k, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                check_val("gap_ready", 32'(CMD_READY), 32'd1);
                check_val("gap_enb", 32'(ENB), 32'd2);
                @(negedge CLK);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
